// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - multicycle ARM main control FSM with memory handshake, wait timeout and fault trap
// Define BL_EN to add the BRLINK state so branch-with-link writes R14 before branching.
module multicycle_main_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       link_sel,
  output logic       fault,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FAULT  = 4'd10,
    S_BRLINK = 4'd11
  } state_t;

  localparam logic [CNT_W-1:0] TMO     = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             fault_q;
  logic             is_mem;
  logic             is_mem_nxt;
  logic             timed_out;
  logic             unused_funct;

  assign unused_funct = ^Funct[4:1];

  assign is_mem     = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign is_mem_nxt = (state_nxt == S_FETCH) || (state_nxt == S_MEMRD) || (state_nxt == S_MEMWR);
  // A completing access in the last allowed cycle still advances normally.
  assign timed_out  = (MEM_TIMEOUT != 0) && is_mem && !mem_ready && (cnt == TMO);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_nxt = S_MEMADR;
`ifdef BL_EN
          2'b10:   state_nxt = Funct[4] ? S_BRLINK : S_BRANCH;
`else
          2'b10:   state_nxt = S_BRANCH;
`endif
          default: state_nxt = S_FAULT;
        endcase
      end
      S_MEMADR: state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
      S_EXECR, S_EXECI: state_nxt = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: state_nxt = S_FETCH;
`ifdef BL_EN
      S_BRLINK: state_nxt = S_BRANCH;
`endif
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_FAULT;
    endcase
    if (timed_out) state_nxt = S_FAULT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_FAULT) fault_q <= 1'b1;
      if (is_mem_nxt && (state_nxt != state)) begin
        cnt <= '0;
      end else if (is_mem && !mem_ready && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Outputs are forced low while reset is held, even though state already reads FETCH.
  always_comb begin
    mem_req   = 1'b0;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'd0;
    ALUSrcB   = 2'd0;
    ResultSrc = 2'd0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    link_sel  = 1'b0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          IRWrite   = mem_ready;
          NextPC    = mem_ready;
          ALUSrcA   = 2'd1;
          ALUSrcB   = 2'd2;
          ResultSrc = 2'd2;
        end
        S_DECODE: begin
          ALUSrcA   = 2'd1;
          ALUSrcB   = 2'd2;
          ResultSrc = 2'd2;
        end
        S_MEMADR: ALUSrcB = 2'd1;
        S_MEMRD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'd1;
          RegW      = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
          MemW    = 1'b1;
        end
        S_EXECR: ALUOp = 1'b1;
        S_EXECI: begin
          ALUSrcB = 2'd1;
          ALUOp   = 1'b1;
        end
        S_ALUWB: RegW = 1'b1;
        S_BRANCH: begin
          ALUSrcB   = 2'd1;
          ResultSrc = 2'd2;
          Branch    = 1'b1;
        end
`ifdef BL_EN
        S_BRLINK: begin
          RegW      = 1'b1;
          link_sel  = 1'b1;
          ResultSrc = 2'd2;
        end
`endif
        default: ;
      endcase
    end
  end

  assign fault   = fault_q;
  assign state_o = state;

endmodule
